cont_sweep_ctrl: RTL and testbench

Sequencer for the 4-bit up/down counter datapath. Accepts a sweep command (limits, mode, sweep count) over a valid/ready handshake, then drives load, enable and direction into an external counter. Watches the counter value to turn at the endpoints and count completed sweeps. Sits between the control/register layer and the counter.

---
 rtl/cont_sweep_ctrl_if.sv | 44 ++++
 rtl/cont_sweep_ctrl.sv | 122 ++++++++++++
 tb/tb_cont_sweep_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cont_sweep_ctrl_if.sv
// Command and counter-control bundle for cont_sweep_ctrl.
// The pause line exists only when CONT_SWEEP_PAUSE_EN is defined.
interface cont_sweep_ctrl_if #(
    parameter int W       = 4,
    parameter int SWEEP_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [W-1:0]       cmd_lo;
    logic [W-1:0]       cmd_hi;
    logic [1:0]         cmd_mode;
    logic [SWEEP_W-1:0] cmd_sweeps;
    logic               stop;
`ifdef CONT_SWEEP_PAUSE_EN
    logic               pause;
`endif
    logic [W-1:0]       cnt_val;
    logic               cnt_load;
    logic [W-1:0]       cnt_load_val;
    logic               cnt_en;
    logic               cnt_up;
    logic               busy;
    logic               done;
    logic               cmd_err;
    logic [SWEEP_W-1:0] sweep_cnt;

    modport master (
`ifdef CONT_SWEEP_PAUSE_EN
        output pause,
`endif
        output cmd_valid, cmd_lo, cmd_hi, cmd_mode, cmd_sweeps, stop, cnt_val,
        input  cmd_ready, cnt_load, cnt_load_val, cnt_en, cnt_up,
        input  busy, done, cmd_err, sweep_cnt
    );

    modport slave (
`ifdef CONT_SWEEP_PAUSE_EN
        input  pause,
`endif
        input  cmd_valid, cmd_lo, cmd_hi, cmd_mode, cmd_sweeps, stop, cnt_val,
        output cmd_ready, cnt_load, cnt_load_val, cnt_en, cnt_up,
        output busy, done, cmd_err, sweep_cnt
    );
endinterface

// File: rtl/cont_sweep_ctrl.sv
// Sweep sequencer driving an external up/down counter between two limits.
// Optional RUN-state pause input enabled by CONT_SWEEP_PAUSE_EN.
module cont_sweep_ctrl #(
    parameter int W       = 4,
    parameter int SWEEP_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    cont_sweep_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN_UP, RUN_DOWN, DONE} state_t;

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DOWN = 2'b01;
    localparam logic [1:0] M_BNC  = 2'b10;

    state_t             state, nxt;
    logic [W-1:0]       lo, hi;
    logic [1:0]         mode;
    logic [SWEEP_W-1:0] sweeps, sweep_cnt;
    logic               done, cmd_err;
    logic               accept, illegal, last, sweep_inc, hold;
    logic               load, en, up;
    logic [W-1:0]       load_val;
    logic [SWEEP_W:0]   sweep_nxt;

`ifdef CONT_SWEEP_PAUSE_EN
    assign hold = bus.pause;
`else
    assign hold = 1'b0;
`endif

    assign accept    = bus.cmd_valid && (state == IDLE);
    assign illegal   = (bus.cmd_lo > bus.cmd_hi) || (bus.cmd_mode == 2'b11);
    assign sweep_nxt = {1'b0, sweep_cnt} + {{SWEEP_W{1'b0}}, 1'b1};
    assign last      = (sweeps != '0) && (sweep_nxt == {1'b0, sweeps});

    always_comb begin
        nxt       = state;
        load      = 1'b0;
        load_val  = '0;
        en        = 1'b0;
        up        = 1'b0;
        sweep_inc = 1'b0;
        case (state)
            IDLE: if (accept && !illegal) nxt = LOAD;
            LOAD: begin
                load_val = (mode == M_DOWN) ? hi : lo;
                if (bus.stop) nxt = IDLE;
                else begin
                    load = 1'b1;
                    nxt  = (mode == M_DOWN) ? RUN_DOWN : RUN_UP;
                end
            end
            RUN_UP: begin
                up = 1'b1;
                if (bus.stop)              nxt = IDLE;
                else if (hold)             nxt = RUN_UP;
                else if (bus.cnt_val != hi) en = 1'b1;
                else if (mode == M_BNC)    nxt = RUN_DOWN;
                else begin
                    sweep_inc = 1'b1;
                    nxt       = last ? DONE : LOAD;
                end
            end
            RUN_DOWN: begin
                if (bus.stop)              nxt = IDLE;
                else if (hold)             nxt = RUN_DOWN;
                else if (bus.cnt_val != lo) en = 1'b1;
                else begin
                    // a bounce round trip completes here, as does a down-only sweep
                    sweep_inc = 1'b1;
                    if (last)              nxt = DONE;
                    else if (mode == M_BNC) nxt = RUN_UP;
                    else                   nxt = LOAD;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lo        <= '0;
            hi        <= '0;
            mode      <= '0;
            sweeps    <= '0;
            sweep_cnt <= '0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state   <= nxt;
            done    <= (nxt == DONE);
            cmd_err <= accept && illegal;
            if (accept && !illegal) begin
                lo        <= bus.cmd_lo;
                hi        <= bus.cmd_hi;
                mode      <= bus.cmd_mode;
                sweeps    <= bus.cmd_sweeps;
                sweep_cnt <= '0;
            end else if (sweep_inc && (sweep_cnt != '1)) begin
                sweep_cnt <= sweep_nxt[SWEEP_W-1:0];
            end
        end
    end

    assign bus.cmd_ready    = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.cnt_load     = load;
    assign bus.cnt_load_val = load_val;
    assign bus.cnt_en       = en;
    assign bus.cnt_up       = up;
    assign bus.done         = done;
    assign bus.cmd_err      = cmd_err;
    assign bus.sweep_cnt    = sweep_cnt;

    // reference M_UP so the mode map stays documented in one place
    logic unused_mode;
    assign unused_mode = (mode == M_UP);
endmodule

// File: tb/tb_cont_sweep_ctrl.sv
// Bench for cont_sweep_ctrl: behavioural counter plus expected per-cycle trace
// built from the sweep rules; random and directed commands.
module tb_cont_sweep_ctrl;
    localparam int W  = 4;
    localparam int SW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cont_sweep_ctrl_if #(.W(W), .SWEEP_W(SW)) bus();
    cont_sweep_ctrl #(.W(W), .SWEEP_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    logic [W-1:0] cnt = '0;
    assign bus.cnt_val = cnt;
    always @(posedge clk) begin
        if (bus.cnt_load)    cnt <= bus.cnt_load_val;
        else if (bus.cnt_en) cnt <= bus.cnt_up ? cnt + 1'b1 : cnt - 1'b1;
    end

    int n_chk = 0;
    int n_err = 0;
    int last_sweeps = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    typedef struct {bit load; bit en; bit run; bit up; int val;} step_t;
    step_t q[$];

    function automatic void add(bit load, bit en, bit run, bit up, int val);
        step_t s;
        s.load = load; s.en = en; s.run = run; s.up = up; s.val = val;
        q.push_back(s);
    endfunction

    // Expected busy cycles before DONE: LOAD steps and one entry per RUN cycle.
    function automatic void build(int lo, int hi, int mode, int n);
        q.delete();
        if (mode == 2) begin
            add(1, 0, 0, 0, lo);
            repeat (n) begin
                for (int v = lo; v <= hi; v++) add(0, v != hi, 1, 1, v);
                for (int v = hi; v >= lo; v--) add(0, v != lo, 1, 0, v);
            end
        end else begin
            repeat (n) begin
                if (mode == 0) begin
                    add(1, 0, 0, 0, lo);
                    for (int v = lo; v <= hi; v++) add(0, v != hi, 1, 1, v);
                end else begin
                    add(1, 0, 0, 0, hi);
                    for (int v = hi; v >= lo; v--) add(0, v != lo, 1, 0, v);
                end
            end
        end
    endfunction

    task automatic send(input int lo, input int hi, input int mode, input int n);
        logic [31:0] t;
        @(negedge clk);
        chk("ready_idle", bus.cmd_ready, 1);
        t = lo;   bus.cmd_lo     = t[W-1:0];
        t = hi;   bus.cmd_hi     = t[W-1:0];
        t = mode; bus.cmd_mode   = t[1:0];
        t = n;    bus.cmd_sweeps = t[SW-1:0];
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input int lo, input int hi, input int mode, input int n);
        bit ill;
        ill = (lo > hi) || (mode == 3);
        send(lo, hi, mode, n);
        if (ill) begin
            @(negedge clk);
            chk("err_pulse", bus.cmd_err, 1);
            chk("err_busy", bus.busy, 0);
            chk("err_load", bus.cnt_load, 0);
            @(negedge clk);
            chk("err_clear", bus.cmd_err, 0);
            chk("err_busy2", bus.busy, 0);
            chk("err_sweep", bus.sweep_cnt, last_sweeps);
        end else begin
            build(lo, hi, mode, n);
            foreach (q[i]) begin
                @(negedge clk);
                chk("run_busy", bus.busy, 1);
                chk("run_load", bus.cnt_load, q[i].load);
                chk("run_en", bus.cnt_en, q[i].en);
                chk("run_done", bus.done, 0);
                if (q[i].load) chk("load_val", bus.cnt_load_val, q[i].val);
                if (q[i].run) begin
                    chk("run_up", bus.cnt_up, q[i].up);
                    chk("run_val", cnt, q[i].val);
                end
            end
            @(negedge clk);
            chk("done_pulse", bus.done, 1);
            chk("done_en", bus.cnt_en, 0);
            chk("done_load", bus.cnt_load, 0);
            @(negedge clk);
            chk("done_clear", bus.done, 0);
            chk("idle_busy", bus.busy, 0);
            chk("idle_ready", bus.cmd_ready, 1);
            chk("sweep_cnt", bus.sweep_cnt, n);
            last_sweeps = n;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, bus.cmd_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_en"}, bus.cnt_en, 0);
        chk({tag, "_load"}, bus.cnt_load, 0);
        chk({tag, "_up"}, bus.cnt_up, 0);
        chk({tag, "_lval"}, bus.cnt_load_val, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.cmd_err, 0);
        chk({tag, "_sweep"}, bus.sweep_cnt, 0);
    endtask

    initial begin
        bit found;
        int lo, hi, mode, n;
        bus.cmd_valid = 1'b0; bus.cmd_lo = '0; bus.cmd_hi = '0;
        bus.cmd_mode = '0; bus.cmd_sweeps = '0; bus.stop = 1'b0;
`ifdef CONT_SWEEP_PAUSE_EN
        bus.pause = 1'b0;
`endif
        #1 chk_reset_vals("rst");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_cmd(0, 15, 2, 1);
        run_cmd(3, 6, 0, 2);
        run_cmd(9, 2, 2, 1);
        run_cmd(0, 1, 3, 1);
        run_cmd(5, 5, 2, 3);
        run_cmd(4, 4, 1, 2);

        repeat (25) begin
            lo   = $urandom_range(0, 15);
            hi   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(lo, 15);
            mode = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            run_cmd(lo, hi, mode, n);
        end

        // stop mid down-sweep
        send(0, 15, 1, 0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (cnt == 4'd7 && bus.busy && !bus.cnt_load) found = 1;
        end
        chk("stop_seen", found, 1);
        bus.stop = 1'b1;
        #1;
        chk("stop_en", bus.cnt_en, 0);
        chk("stop_load", bus.cnt_load, 0);
        @(posedge clk);
        #1 bus.stop = 1'b0;
        chk("stop_nodone", bus.done, 0);
        @(negedge clk);
        chk("stop_busy", bus.busy, 0);
        chk("stop_done", bus.done, 0);
        chk("stop_sweep", bus.sweep_cnt, 0);
        last_sweeps = 0;

`ifdef CONT_SWEEP_PAUSE_EN
        send(0, 15, 2, 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (cnt == 4'd15 && bus.cnt_up) found = 1;
        end
        chk("pause_seen", found, 1);
        bus.pause = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("pause_en", bus.cnt_en, 0);
            chk("pause_up", bus.cnt_up, 1);
            chk("pause_val", cnt, 15);
            chk("pause_sweep", bus.sweep_cnt, 0);
        end
        bus.pause = 1'b0;
        @(negedge clk);
        chk("unpause_down", bus.cnt_up, 0);
        chk("unpause_en", bus.cnt_en, 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.done) found = 1;
        end
        chk("pause_done", found, 1);
        @(negedge clk);
        chk("pause_sweep_end", bus.sweep_cnt, 1);
`endif

        // asynchronous reset mid-run
        send(2, 12, 2, 0);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1);
        #2 reset = 1'b0;
        #1 chk_reset_vals("arst");
        @(negedge clk);
        reset = 1'b1;
        last_sweeps = 0;
        run_cmd(1, 3, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
